// File: rtl/poly_tone_generator.sv
// Polyphonic square-wave tone generator.
// Each voice runs a half-period counter that toggles a phase bit. A voice's
// output is gated by a shared PWM counter compared against its volume.
// A registered output time-multiplexes all voices onto one pin.
// A period rewrite to a running voice is deferred to its next toggle, so a
// tone never changes pitch part-way through a half-period.
module poly_tone_generator #(
  parameter int NUM_VOICES   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int VOLUME_BITS  = 4,
  parameter int VOICE_IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    output_enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [VOICE_IDX_W-1:0]  cfg_voice,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic [VOLUME_BITS-1:0]  cfg_volume,
  output logic [NUM_VOICES-1:0]   voice_wave,
  output logic                    square_wave_out
);

  logic [NUM_VOICES-1:0]  pending_vec;
  logic [NUM_VOICES-1:0]  voice_hit;
  logic [VOLUME_BITS-1:0] pwm_cnt;
  logic [VOICE_IDX_W-1:0] mix_sel;
  logic                   mixed;

  // Decode the target voice and derive ready; an out-of-range index hits no
  // voice, so it is always ready and changes nothing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop leaves it unassigned and no latch is inferred.
    voice_hit = '0;
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (cfg_voice == VOICE_IDX_W'(i)) begin
        voice_hit[i] = 1'b1;
        cfg_ready    = ~pending_vec[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] pend_period;
    logic [PERIOD_WIDTH-1:0] counter;
    logic [VOLUME_BITS-1:0]  volume;
    logic                    phase;
    logic                    pending;
    logic                    wr;
    logic                    at_end;

    assign wr     = cfg_valid & cfg_ready & voice_hit[gi];
    // Full-width compare: period - 1 never wraps because period is nonzero.
    assign at_end = (period != '0) && (counter == period - 1'b1);

    // Per-voice tone state: half-period counting, deferred period load and
    // config writes. Config writes come last so they win on the same edge.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: every per-voice register is reset, not just the control bits,
      // because a discarded pending period must never reappear after reset.
      if (rst) begin
        period      <= '0;
        pend_period <= '0;
        counter     <= '0;
        volume      <= '1;
        phase       <= 1'b0;
        pending     <= 1'b0;
      end else begin
        // NOTE: state registers use non-blocking assignments so every
        // decision in this block sees the pre-edge values.
        if (period == '0) begin
          counter <= '0;
          phase   <= 1'b0;
        end else if (at_end) begin
          counter <= '0;
          if (pending) begin
            pending <= 1'b0;
            period  <= pend_period;
            phase   <= (pend_period == '0) ? 1'b0 : ~phase;
          end else begin
            phase <= ~phase;
          end
        end else begin
          counter <= counter + 1'b1;
        end

        if (wr) begin
          volume <= cfg_volume;
          if (period == '0) begin
            period  <= cfg_period;
            counter <= '0;
            phase   <= 1'b0;
          end else begin
            pend_period <= cfg_period;
            pending     <= 1'b1;
          end
        end
      end
    end

    assign pending_vec[gi] = pending;
    assign voice_wave[gi]  = output_enable & phase & (pwm_cnt <= volume);
  end

  // Shared free-running PWM counter and mix selector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      mix_sel <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      mix_sel <= (mix_sel == VOICE_IDX_W'(NUM_VOICES - 1)) ? '0 : mix_sel + 1'b1;
    end
  end

  // Pick the currently selected voice for the mixed output.
  always_comb begin
    mixed = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (mix_sel == VOICE_IDX_W'(i)) mixed = voice_wave[i];
    end
  end

  // Register the mix, one cycle behind the selected voice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) square_wave_out <= 1'b0;
    else     square_wave_out <= output_enable & mixed;
  end

endmodule
